// File: rtl/f_add_pkg.sv
// Shared definitions for the binary32 adder: field widths, constants and the
// stage-1 to stage-2 pipeline record.
package f_add_pkg;

  localparam int unsigned EXP_W   = 8;
  localparam int unsigned MAN_W   = 23;
  localparam int unsigned BIAS    = 127;
  localparam int unsigned EXP_MAX = 255;
  localparam int unsigned LATENCY = 2;
  // Hidden bit + fraction + guard/round/sticky.
  localparam int unsigned SUM_W   = MAN_W + 4;

  localparam logic [31:0] QNAN = 32'h7FC00000;

  // Aligned, added operands handed from stage 1 to stage 2.
  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic             carry;   // carry out of the 27-bit magnitude sum
    logic [SUM_W-1:0] sum;
    logic             is_nan;
    logic             is_inf;
    logic             flag;
    logic [4:0]       add;
  } s1_t;

endpackage

// File: rtl/f_add_lzc.sv
// 27-bit leading-zero counter, combinational. An all-zero input yields 27.
module f_add_lzc (
  input  logic [26:0] din,
  output logic [4:0]  cnt
);

  logic found;

  // Scan from the MSB and stop at the first set bit.
  always_comb begin
    cnt   = 5'd27;
    found = 1'b0;
    for (int i = 26; i >= 0; i--) begin
      if (!found && din[i]) begin
        cnt   = 5'(26 - i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/f_add.sv
// Two-stage pipelined IEEE-754 binary32 adder with round-to-nearest-even.
// Subnormal inputs and results are flushed to zero. Define F_ADD_SPECIAL_EN to
// give exp=255 inputs (inf/NaN) IEEE behaviour; otherwise they are treated as
// ordinary finite values.
module f_add
  import f_add_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] x1,
  input  logic [31:0] x2,
  input  logic        flagin,
  input  logic [4:0]  addin,
  output logic [31:0] y,
  output logic        flagout,
  output logic [4:0]  addout
);

  s1_t s1_d, s1_q;

  logic [EXP_W-1:0] ea, eb, e_big, e_small, diff;
  logic [MAN_W-1:0] fa, fb;
  logic [23:0]      m_big, m_small;
  logic [52:0]      shifted;
  logic [26:0]      aligned, big27;
  logic [27:0]      sum28;
  logic             a_big, eff_sub;

  // Stage 1: unpack, order by magnitude, align the smaller operand, add/subtract.
  always_comb begin
    ea      = x1[30:23];
    eb      = x2[30:23];
    fa      = (ea == '0) ? '0 : x1[22:0];
    fb      = (eb == '0) ? '0 : x2[22:0];
    a_big   = {ea, fa} >= {eb, fb};
    e_big   = a_big ? ea : eb;
    e_small = a_big ? eb : ea;
    m_big   = a_big ? {|ea, fa} : {|eb, fb};
    m_small = a_big ? {|eb, fb} : {|ea, fa};
    eff_sub = x1[31] ^ x2[31];
    diff    = e_big - e_small;
    // Wide shift keeps every bit pushed past the sticky position for the OR.
    shifted = {m_small, 29'b0} >> diff;
    if (diff >= 8'd26) aligned = {26'b0, |m_small};
    else               aligned = shifted[52:26] | {26'b0, |shifted[25:0]};
    big27 = {m_big, 3'b000};
    // Ordering guarantees big >= small, so subtraction never borrows.
    if (eff_sub) sum28 = {1'b0, big27} - {1'b0, aligned};
    else         sum28 = {1'b0, big27} + {1'b0, aligned};

    s1_d.sign   = a_big ? x1[31] : x2[31];
    s1_d.exp    = e_big;
    s1_d.carry  = sum28[27];
    s1_d.sum    = sum28[26:0];
    s1_d.is_nan = 1'b0;
    s1_d.is_inf = 1'b0;
    s1_d.flag   = flagin;
    s1_d.add    = addin;
`ifdef F_ADD_SPECIAL_EN
    begin
      logic a_nan, b_nan, a_inf, b_inf;
      a_nan = (ea == 8'hFF) && (x1[22:0] != '0);
      b_nan = (eb == 8'hFF) && (x2[22:0] != '0);
      a_inf = (ea == 8'hFF) && (x1[22:0] == '0);
      b_inf = (eb == 8'hFF) && (x2[22:0] == '0);
      if (a_nan || b_nan || (a_inf && b_inf && (x1[31] != x2[31]))) begin
        s1_d.is_nan = 1'b1;
      end else if (a_inf || b_inf) begin
        s1_d.is_inf = 1'b1;
        s1_d.sign   = a_inf ? x1[31] : x2[31];
      end
    end
`endif
  end

  // Stage-1 pipeline register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) s1_q <= '0;
    else     s1_q <= s1_d;
  end

  logic [4:0]  lz;
  logic [26:0] mant;
  logic [9:0]  exp_n, exp_r;
  logic [24:0] rnd;
  logic [22:0] frac;
  logic        round_up;
  logic [31:0] y_d;

  f_add_lzc u_lzc (
    .din (s1_q.sum),
    .cnt (lz)
  );

  // Stage 2: normalize, round to nearest even, renormalize, pack.
  always_comb begin
    if (s1_q.carry) begin
      mant  = {1'b1, s1_q.sum[26:2], s1_q.sum[1] | s1_q.sum[0]};
      exp_n = {2'b00, s1_q.exp} + 10'd1;
    end else begin
      mant  = s1_q.sum << lz;
      exp_n = {2'b00, s1_q.exp} - {5'b0, lz};
    end
    round_up = mant[2] & (mant[1] | mant[0] | mant[3]);
    rnd      = {1'b0, mant[26:3]} + {24'b0, round_up};
    if (rnd[24]) begin
      exp_r = exp_n + 10'd1;
      frac  = rnd[23:1];
    end else begin
      exp_r = exp_n;
      frac  = rnd[22:0];
    end

    if (s1_q.is_nan)                              y_d = QNAN;
    else if (s1_q.is_inf)                         y_d = {s1_q.sign, 8'hFF, 23'b0};
    else if (!s1_q.carry && (s1_q.sum == '0))     y_d = 32'h0;
    else if (exp_r[9] || (exp_r == '0))           y_d = {s1_q.sign, 31'b0};
    else if (exp_r >= 10'(EXP_MAX))               y_d = {s1_q.sign, 8'hFF, 23'b0};
    else                                          y_d = {s1_q.sign, exp_r[7:0], frac};
  end

  // Output registers, with the sideband tags kept aligned to the result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y       <= '0;
      flagout <= 1'b0;
      addout  <= '0;
    end else begin
      y       <= y_d;
      flagout <= s1_q.flag;
      addout  <= s1_q.add;
    end
  end

endmodule

// File: tb/tb_f_add.sv
// Self-checking bench for f_add: directed corner cases, tag alignment, reset
// mid-stream and a randomized sweep against a real-arithmetic reference.
module tb_f_add;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] x1, x2, y;
  logic        flagin, flagout;
  logic [4:0]  addin, addout;

  int tests = 0;
  int fails = 0;

  logic        pend_v;
  logic [31:0] pend_y;
  logic        pend_f;
  logic [4:0]  pend_a;
  logic        pend_exact;
  logic        pend_chk;

  always #5 clk = ~clk;

  f_add dut (
    .clk     (clk),
    .rst     (rst),
    .x1      (x1),
    .x2      (x2),
    .flagin  (flagin),
    .addin   (addin),
    .y       (y),
    .flagout (flagout),
    .addout  (addout)
  );

  // binary32 -> real, with exp=0 read as zero.
  function automatic real to_real(input logic [31:0] v);
    logic [63:0] d;
    if (v[30:23] == 8'h00) return 0.0;
    d = {v[31], {3'b000, v[30:23]} + 11'd896, v[22:0], 29'b0};
    return $bitstoreal(d);
  endfunction

  // Reference sum: exact-ish real addition, then RNE to binary32 with flush/overflow.
  function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b);
    real         r;
    logic [63:0] d;
    int          e;
    logic [23:0] man;
    logic [28:0] rest;
    logic [24:0] m25;
    logic        up;
    r = to_real(a) + to_real(b);
    if (r == 0.0) return 32'h0;
    d    = $realtobits(r);
    e    = int'(d[62:52]) - 1023 + 127;
    man  = {1'b1, d[51:29]};
    rest = d[28:0];
    up   = (rest > 29'h1000_0000) || ((rest == 29'h1000_0000) && man[0]);
    m25  = {1'b0, man} + {24'b0, up};
    if (m25[24]) begin
      e++;
      m25 = m25 >> 1;
    end
    if (e <= 0)   return {d[63], 31'b0};
    if (e >= 255) return {d[63], 8'hFF, 23'b0};
    return {d[63], e[7:0], m25[22:0]};
  endfunction

  function automatic bit ulp_ok(input logic [31:0] got, input logic [31:0] want);
    int dd;
    if (got === want) return 1'b1;
    if ((^got) === 1'bx) return 1'b0;
    if (got[31] != want[31]) return 1'b0;
    dd = int'({1'b0, got[30:0]}) - int'({1'b0, want[30:0]});
    return (dd >= -1) && (dd <= 1);
  endfunction

  task automatic check_pending();
    if (pend_v) begin
      if (pend_chk) begin
        tests++;
        if (pend_exact) begin
          assert (y === pend_y) else begin
            fails++;
            $error("FAIL y_exact got=%h want=%h", y, pend_y);
          end
        end else begin
          assert (ulp_ok(y, pend_y) === 1'b1) else begin
            fails++;
            $error("FAIL y_ulp got=%h want=%h (+-1 ulp)", y, pend_y);
          end
        end
      end
      tests++;
      assert (flagout === pend_f) else begin
        fails++;
        $error("FAIL flagout got=%b want=%b", flagout, pend_f);
      end
      tests++;
      assert (addout === pend_a) else begin
        fails++;
        $error("FAIL addout got=%h want=%h", addout, pend_a);
      end
    end
  endtask

  // Present one operand pair; the result of the previous pair is checked after this edge.
  task automatic step(input logic [31:0] a, input logic [31:0] b, input logic f,
                      input logic [4:0] ad, input logic [31:0] want, input bit exact,
                      input bit chk);
    x1 = a; x2 = b; flagin = f; addin = ad;
    @(posedge clk);
    #1;
    check_pending();
    pend_v = 1'b1; pend_y = want; pend_f = f; pend_a = ad;
    pend_exact = exact; pend_chk = chk;
    @(negedge clk);
  endtask

  task automatic drain();
    @(posedge clk);
    #1;
    check_pending();
    pend_v = 1'b0;
    @(negedge clk);
  endtask

  logic [22:0] corners [7];
  logic [31:0] ra, rb, r32;
  logic [7:0]  ea, eb;
  logic [22:0] ma, mb;
  logic        sa, sb;
  int          kind, t;

  initial begin
    corners = '{23'h0, 23'h1, 23'h2, 23'h380000, 23'h400000, 23'h5FFFFF, 23'h7FFFFF};
    pend_v = 1'b0; pend_y = '0; pend_f = 1'b0; pend_a = '0; pend_exact = 1'b1; pend_chk = 1'b1;
    rst = 1'b1; x1 = '0; x2 = '0; flagin = 1'b0; addin = '0;
    repeat (2) @(negedge clk);
    tests++;
    assert (y === 32'h0) else begin fails++; $error("FAIL reset_y got=%h want=%h", y, 32'h0); end
    tests++;
    assert (flagout === 1'b0) else begin fails++; $error("FAIL reset_flag got=%b want=0", flagout); end
    tests++;
    assert (addout === 5'h0) else begin fails++; $error("FAIL reset_add got=%h want=00", addout); end
    rst = 1'b0;
    @(negedge clk);

    // Directed: back-to-back stream with distinct tags, then corner cases.
    step(32'h3F800000, 32'h3F800000, 1'b1, 5'h1A, 32'h40000000, 1, 1);
    step(32'h3F800000, 32'hBF800000, 1'b0, 5'h05, 32'h00000000, 1, 1);
    step(32'h3F800000, 32'h33800000, 1'b1, 5'h03, 32'h3F800000, 1, 1);
    step(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 5'h11, 32'h7F800000, 1, 1);
    step(32'h00800001, 32'h80800000, 1'b1, 5'h1F, 32'h00000000, 1, 1);
    step(32'h40400000, 32'hC0000000, 1'b0, 5'h0C, 32'h3F800000, 1, 1);

    // Reset while two ops are in flight: outputs clear at once, in-flight op is lost.
    step(32'h40000000, 32'h40000000, 1'b1, 5'h15, 32'h40800000, 1, 1);
    step(32'h3F800000, 32'h40000000, 1'b1, 5'h0A, 32'h40400000, 1, 1);
    rst = 1'b1;
    #1;
    tests++;
    assert (y === 32'h0) else begin fails++; $error("FAIL midrst_y got=%h want=%h", y, 32'h0); end
    tests++;
    assert (flagout === 1'b0) else begin fails++; $error("FAIL midrst_flag got=%b want=0", flagout); end
    tests++;
    assert (addout === 5'h0) else begin fails++; $error("FAIL midrst_add got=%h want=00", addout); end
    @(negedge clk);
    rst = 1'b0;
    // The discarded op must not emerge: first output after reset is the cleared pipeline.
    pend_v = 1'b1; pend_y = 32'h0; pend_f = 1'b0; pend_a = 5'h0; pend_exact = 1'b1; pend_chk = 1'b1;
    step(32'h40A00000, 32'h3F800000, 1'b1, 5'h07, 32'h40C00000, 1, 1);
    step(32'hC0A00000, 32'h3F800000, 1'b0, 5'h19, 32'hC0800000, 1, 1);

    // Randomized sweep.
    for (int i = 0; i < 400; i++) begin
      kind = int'($urandom_range(0, 3));
      ea = 8'($urandom_range(0, 254));
      sa = 1'($urandom_range(0, 1));
      sb = 1'($urandom_range(0, 1));
      r32 = $urandom();
      ma = ($urandom_range(0, 1) == 0) ? corners[$urandom_range(0, 6)] : r32[22:0];
      r32 = $urandom();
      mb = ($urandom_range(0, 1) == 0) ? corners[$urandom_range(0, 6)] : r32[22:0];
      unique case (kind)
        0: eb = 8'($urandom_range(0, 254));
        1: eb = ea;
        2: begin
          t = int'(ea) - int'($urandom_range(0, 30));
          if (t < 0) t = 0;
          eb = 8'(t);
        end
        default: begin
          eb = ea;
          sb = ~sa;
          r32 = $urandom();
          mb = ($urandom_range(0, 3) == 0) ? ma : (ma ^ (r32[22:0] >> $urandom_range(0, 22)));
        end
      endcase
      ra = {sa, ea, ma};
      rb = {sb, eb, mb};
      step(ra, rb, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), ref_add(ra, rb), 0,
           !((ea == 8'h00) && (eb == 8'h00)));
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
